branch_predictor_gshare: RTL and testbench
==========================================

Name: branch_predictor_gshare

Overview:
- Parametrised successor to the in-order bimodal branch predictor in instFetch.
- Sits beside the fetch/decoder path and predicts conditional branches in the same cycle: taken/not-taken plus the next fetch address.
- Tracks outstanding predictions in an in-order resolution queue, checked against CDB broadcasts.
- New versus the previous generation:
  - selectable gshare/bimodal indexing;
  - speculative global history with recovery;
  - configurable counter width and depths;
  - back-pressure output replaces simulation-abort on overflow;
  - external flush input;
  - performance counters.

Parameters:
- PHT_W, 6, log2 of pattern-history-table entries.
- HIST_W, 6, global history length; must be <= PHT_W.
- CTR_W, 2, saturating counter width; must be >= 2.
- BQ_W, 3, log2 of resolution queue depth.
- MODE, 1, indexing mode: 0 = bimodal (pc only), 1 = gshare (pc xor history).

Ports:
- clk_in, in, 1, clock.
- rst_in, in, 1, reset, asynchronous, active-low.
- rdy_in, in, 1, global ready; low freezes all state.
- branch_in, in, 1, decoder flags a conditional branch at pc_in.
- imm_in, in, 32, branch offset.
- inst_length_in, in, 1, 1 = 4-byte instruction, 0 = 2-byte.
- foq_full_in, in, 1, fetch output queue full.
- pc_in, in, 32, pc of the current instruction.
- cdb_active_in, in, 1, CDB broadcast valid.
- cdb_addr_in, in, 32, source pc of the broadcast.
- cdb_val_in, in, 32, bit0 = actual taken.
- flush_in, in, 1, external redirect: discard all outstanding predictions.
- bq_full_out, out, 1, resolution queue full; fetch must stall branches.
- need_branch_out, out, 1, predicted taken.
- branch_addr_out, out, 32, predicted next pc.
- predict_fail_out, out, 1, head prediction was wrong.
- fail_addr_out, out, 32, corrected pc.
- stat_resolved_out, out, 32, count of resolved branches.
- stat_mispredict_out, out, 32, count of mispredicts.

Behaviour:
- Reset (async, rst_in=0):
  - every PHT counter = 2^(CTR_W-1)-1 (weakly not-taken);
  - spec_ghr = arch_ghr = 0;
  - queue front = rear = count = 0;
  - stat counters = 0;
  - all outputs 0.
- Predict enable:
  - need_predict = branch_in & rdy_in & !foq_full_in & !bq_full_out & !flush_in & !predict_fail_out.
- Index:
  - MODE=0: pc_in[PHT_W:1].
  - MODE=1: pc_in[PHT_W:1] xor zero-extended spec_ghr.
- Prediction (combinational, zero latency):
  - need_branch_out = need_predict & counter[index] MSB.
  - branch_addr_out = taken ? pc_in+imm_in : pc_in+(inst_length_in?4:2); 0 when !need_predict.
  - Fail address is the other of the two targets.
- Push (on the clock edge when need_predict):
  - entry {pc, fail_addr, pred, index} written at rear;
  - rear wraps modulo 2^BQ_W;
  - spec_ghr <= {spec_ghr[HIST_W-2:0], pred}.
- Resolve hit: rdy_in & cdb_active_in & count!=0 & cdb_addr_in==head.pc & cdb_addr_in!=0. A non-matching broadcast is ignored.
- On every hit:
  - counter[head.index] saturates up if actual=1, down if actual=0; it holds at all-ones or zero;
  - arch_ghr shifts in actual;
  - stat_resolved increments, wrapping at 2^32.
- predict_fail_out = hit & head.pred != actual; fail_addr_out = head.fail_addr, else 0.
- On mispredict:
  - queue cleared (front = rear = count = 0);
  - spec_ghr <= {arch_ghr[HIST_W-2:0], actual};
  - stat_mispredict increments;
  - a push in the same cycle is suppressed.
- On a correct hit: pop front.
  - A simultaneous push and pop leave count unchanged.
  - Full plus a pop still does not admit a push that cycle, because bq_full_out is registered-state based.
- flush_in (when rdy_in):
  - queue cleared; spec_ghr <= arch_ghr;
  - no push;
  - a resolve hit in the same cycle still updates the PHT, arch_ghr and stats;
  - if that hit is also a mispredict, its spec_ghr recovery value takes priority.
- bq_full_out = (count == 2^BQ_W).
- rdy_in=0: no state changes; need_branch_out = predict_fail_out = 0.
- Reset asserted mid-operation: immediate clear of the queue and history; the PHT is reinitialised.

Decomposition:
- Shared package/macros file:
  - BP_PHT_W, BP_HIST_W, BP_CTR_W, BP_BQ_W defaults;
  - mode constants BP_MODE_BIMODAL = 0, BP_MODE_GSHARE = 1;
  - queue entry field offsets.
- One natural sub-module: bp_resolve_queue.
  - Circular FIFO with front/rear/count, push, pop and clear.
  - Exposes head fields and full/empty.
- PHT, history and stats stay in the top module.

Test Plan:
- Reset, MODE=1, pc=0x100, imm=0x20, 4-byte branch -> need_branch=0, branch_addr=0x104; the queue holds 1 entry; spec_ghr=0b000000.
- Same branch resolved taken 2 times (cdb_addr=0x100, val=1) -> first resolve gives predict_fail=1, fail_addr=0x120, queue cleared; counter reaches 3 and saturates; the next prediction for 0x100 with matching history gives need_branch=1, branch_addr=0x120.
- Push 8 branches with BQ_W=3 and no resolution -> bq_full_out=1; a 9th branch_in produces need_branch=0, branch_addr=0 and no push; resolving the head correctly drops bq_full_out next cycle.
- Push pcs 0x200, 0x204, 0x208 (predicted NT), then resolve 0x204 first -> no action; resolve 0x200 NT -> pop with no fail; stat_resolved=1, stat_mispredict=0.
- Mispredict on the head while branch_in is asserted the same cycle -> no push; spec_ghr equals arch_ghr shifted with the actual outcome; count=0.
- flush_in with 3 outstanding entries -> count=0, spec_ghr=arch_ghr. Drop rdy_in for 5 cycles with cdb_active set -> no state change. Assert rst_in low asynchronously mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_predictor_gshare_pkg.sv
// Shared defaults, mode encodings and resolution-queue entry layout for the gshare predictor.
package branch_predictor_gshare_pkg;

  localparam int unsigned BP_PHT_W  = 6;
  localparam int unsigned BP_HIST_W = 6;
  localparam int unsigned BP_CTR_W  = 2;
  localparam int unsigned BP_BQ_W   = 3;

  localparam int unsigned BP_MODE_BIMODAL = 0;
  localparam int unsigned BP_MODE_GSHARE  = 1;

  // Entry layout: {index, pred, fail_addr, pc}, index width follows PHT_W.
  localparam int unsigned BP_ENT_PC_LSB   = 0;
  localparam int unsigned BP_ENT_FAIL_LSB = 32;
  localparam int unsigned BP_ENT_PRED_BIT = 64;
  localparam int unsigned BP_ENT_IDX_LSB  = 65;

  function automatic int unsigned bp_entry_w(input int unsigned pht_w);
    return BP_ENT_IDX_LSB + pht_w;
  endfunction

endpackage

// File: rtl/bp_resolve_queue.sv
// Circular FIFO of outstanding predictions, resolved strictly in order.
module bp_resolve_queue
  import branch_predictor_gshare_pkg::*;
#(
  parameter int unsigned DATA_W  = bp_entry_w(BP_PHT_W),
  parameter int unsigned DEPTH_W = BP_BQ_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;
  localparam int unsigned CNT_W = DEPTH_W + 1;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH_W-1:0] front;
  logic [DEPTH_W-1:0] rear;
  logic [CNT_W-1:0]   count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front <= '0;
      rear  <= '0;
      count <= '0;
    end else if (clear) begin
      front <= '0;
      rear  <= '0;
      count <= '0;
    end else begin
      if (push) rear <= rear + DEPTH_W'(1);
      if (pop)  front <= front + DEPTH_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[rear] <= wdata;
  end

  assign head  = mem[front];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/branch_predictor_gshare.sv
// Same-cycle conditional-branch predictor (gshare or bimodal) with in-order CDB resolution,
// speculative history recovery and resolve/mispredict statistics.
module branch_predictor_gshare
  import branch_predictor_gshare_pkg::*;
#(
  parameter int unsigned PHT_W  = BP_PHT_W,
  parameter int unsigned HIST_W = BP_HIST_W,
  parameter int unsigned CTR_W  = BP_CTR_W,
  parameter int unsigned BQ_W   = BP_BQ_W,
  parameter int unsigned MODE   = BP_MODE_GSHARE
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        branch_in,
  input  logic [31:0] imm_in,
  input  logic        inst_length_in,
  input  logic        foq_full_in,
  input  logic [31:0] pc_in,
  input  logic        cdb_active_in,
  input  logic [31:0] cdb_addr_in,
  input  logic [31:0] cdb_val_in,
  input  logic        flush_in,
  output logic        bq_full_out,
  output logic        need_branch_out,
  output logic [31:0] branch_addr_out,
  output logic        predict_fail_out,
  output logic [31:0] fail_addr_out,
  output logic [31:0] stat_resolved_out,
  output logic [31:0] stat_mispredict_out
);

  localparam int unsigned PHT_N = 1 << PHT_W;
  localparam int unsigned ENT_W = bp_entry_w(PHT_W);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  logic [CTR_W-1:0]  pht [PHT_N];
  logic [HIST_W-1:0] spec_ghr, spec_ghr_nxt;
  logic [HIST_W-1:0] arch_ghr, arch_ghr_shift, arch_ghr_upd;
  logic [ENT_W-1:0]  head, push_data;
  logic              q_full, q_empty, q_pop, q_clear;
  logic [PHT_W-1:0]  pc_idx, idx, head_idx;
  logic [31:0]       head_pc, head_fail, taken_addr, seq_addr;
  logic              head_pred, ctr_taken, need_predict;
  logic              hit, actual, mispredict, flush_now;
  logic              unused_cdb_val;

  assign head_pc   = head[BP_ENT_PC_LSB +: 32];
  assign head_fail = head[BP_ENT_FAIL_LSB +: 32];
  assign head_pred = head[BP_ENT_PRED_BIT];
  assign head_idx  = head[BP_ENT_IDX_LSB +: PHT_W];

  assign actual         = cdb_val_in[0];
  assign unused_cdb_val = ^cdb_val_in[31:1];

  assign hit = rdy_in & cdb_active_in & !q_empty
             & (cdb_addr_in == head_pc) & (cdb_addr_in != '0);
  assign mispredict = hit & (head_pred != actual);
  assign flush_now  = rdy_in & flush_in;

  // rst_in term keeps the combinational outputs at zero while reset is held.
  assign need_predict = rst_in & branch_in & rdy_in & !foq_full_in & !q_full
                      & !flush_in & !mispredict;

  assign pc_idx    = pc_in[PHT_W:1];
  assign idx       = (MODE == BP_MODE_GSHARE) ? (pc_idx ^ PHT_W'(spec_ghr)) : pc_idx;
  assign ctr_taken = pht[idx][CTR_W-1];

  assign taken_addr = pc_in + imm_in;
  assign seq_addr   = pc_in + (inst_length_in ? 32'd4 : 32'd2);

  assign need_branch_out  = need_predict & ctr_taken;
  assign branch_addr_out  = !need_predict ? '0 : (ctr_taken ? taken_addr : seq_addr);
  assign predict_fail_out = mispredict;
  assign fail_addr_out    = mispredict ? head_fail : '0;
  assign bq_full_out      = q_full;

  always_comb begin
    push_data                               = '0;
    push_data[BP_ENT_PC_LSB +: 32]          = pc_in;
    push_data[BP_ENT_FAIL_LSB +: 32]        = ctr_taken ? seq_addr : taken_addr;
    push_data[BP_ENT_PRED_BIT]              = ctr_taken;
    push_data[BP_ENT_IDX_LSB +: PHT_W]      = idx;
  end

  assign q_pop   = hit & !mispredict;
  assign q_clear = mispredict | flush_now;

  bp_resolve_queue #(
    .DATA_W (ENT_W),
    .DEPTH_W(BQ_W)
  ) u_queue (
    .clk  (clk_in),
    .rst_n(rst_in),
    .push (need_predict),
    .pop  (q_pop),
    .clear(q_clear),
    .wdata(push_data),
    .head (head),
    .full (q_full),
    .empty(q_empty)
  );

  // Recovery (mispredict or flush) restarts speculation from the post-resolve architectural history.
  assign arch_ghr_shift = HIST_W'({arch_ghr, actual});
  assign arch_ghr_upd   = hit ? arch_ghr_shift : arch_ghr;

  always_comb begin
    spec_ghr_nxt = spec_ghr;
    if (q_clear)           spec_ghr_nxt = arch_ghr_upd;
    else if (need_predict) spec_ghr_nxt = HIST_W'({spec_ghr, ctr_taken});
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      spec_ghr            <= '0;
      arch_ghr            <= '0;
      stat_resolved_out   <= '0;
      stat_mispredict_out <= '0;
    end else begin
      spec_ghr <= spec_ghr_nxt;
      if (hit) begin
        arch_ghr          <= arch_ghr_shift;
        stat_resolved_out <= stat_resolved_out + 32'd1;
      end
      if (mispredict) stat_mispredict_out <= stat_mispredict_out + 32'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < PHT_N; i++) pht[i] <= CTR_INIT;
    end else if (hit) begin
      if (actual && (pht[head_idx] != CTR_MAX))
        pht[head_idx] <= pht[head_idx] + CTR_W'(1);
      else if (!actual && (pht[head_idx] != '0))
        pht[head_idx] <= pht[head_idx] - CTR_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Randomised and directed bench for branch_predictor_gshare against a queue/array reference model.
module tb_branch_predictor_gshare;

  localparam int unsigned PHT_W  = 6;
  localparam int unsigned HIST_W = 6;
  localparam int unsigned CTR_W  = 2;
  localparam int unsigned BQ_W   = 3;
  localparam int unsigned MODE   = 1;
  localparam int DEPTH    = 1 << BQ_W;
  localparam int PHT_N    = 1 << PHT_W;
  localparam int CTR_TOP  = (1 << CTR_W) - 1;
  localparam int CTR_HALF = 1 << (CTR_W - 1);
  localparam int HMASK    = (1 << HIST_W) - 1;
  localparam int PMASK    = (1 << PHT_W) - 1;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, branch_in, inst_length_in, foq_full_in;
  logic        cdb_active_in, flush_in;
  logic [31:0] imm_in, pc_in, cdb_addr_in, cdb_val_in;
  logic        bq_full_out, need_branch_out, predict_fail_out;
  logic [31:0] branch_addr_out, fail_addr_out, stat_resolved_out, stat_mispredict_out;

  branch_predictor_gshare #(
    .PHT_W(PHT_W), .HIST_W(HIST_W), .CTR_W(CTR_W), .BQ_W(BQ_W), .MODE(MODE)
  ) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .branch_in          (branch_in),
    .imm_in             (imm_in),
    .inst_length_in     (inst_length_in),
    .foq_full_in        (foq_full_in),
    .pc_in              (pc_in),
    .cdb_active_in      (cdb_active_in),
    .cdb_addr_in        (cdb_addr_in),
    .cdb_val_in         (cdb_val_in),
    .flush_in           (flush_in),
    .bq_full_out        (bq_full_out),
    .need_branch_out    (need_branch_out),
    .branch_addr_out    (branch_addr_out),
    .predict_fail_out   (predict_fail_out),
    .fail_addr_out      (fail_addr_out),
    .stat_resolved_out  (stat_resolved_out),
    .stat_mispredict_out(stat_mispredict_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] fail;
    bit          pred;
    int          idx;
  } ent_t;

  ent_t        mq[$];
  int          pht_m [PHT_N];
  int          spec_m, arch_m;
  logic [31:0] res_m, mis_m;
  int          n_chk = 0;
  int          n_err = 0;
  bit          chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PHT_N; i++) pht_m[i] = CTR_HALF - 1;
    spec_m = 0;
    arch_m = 0;
    mq.delete();
    res_m = '0;
    mis_m = '0;
  endtask

  // Per-cycle compare against the model, then advance the model to the post-edge state.
  bit          m_hit, m_fail, m_need, m_pred, m_act;
  int          m_idx, m_j;
  logic [31:0] m_tt, m_ts, m_addr, m_faddr;
  ent_t        m_e;

  always @(negedge clk_in) begin
    if (chk_en) begin
      m_act = cdb_val_in[0];
      m_hit = 1'b0;
      if (mq.size() > 0)
        m_hit = rdy_in && cdb_active_in && (cdb_addr_in != 32'h0) && (cdb_addr_in == mq[0].pc);
      m_fail = 1'b0;
      m_faddr = 32'h0;
      if (m_hit) begin
        m_fail = (mq[0].pred != m_act);
        if (m_fail) m_faddr = mq[0].fail;
      end
      m_need = branch_in && rdy_in && !foq_full_in && (mq.size() < DEPTH) && !flush_in && !m_fail;
      m_idx = int'((pc_in >> 1) & 32'(PMASK));
      if (MODE == 1) m_idx = m_idx ^ spec_m;
      m_pred = pht_m[m_idx] >= CTR_HALF;
      m_tt = pc_in + imm_in;
      m_ts = pc_in + (inst_length_in ? 32'd4 : 32'd2);
      m_addr = !m_need ? 32'h0 : (m_pred ? m_tt : m_ts);

      chk("need_branch", 32'(need_branch_out), 32'(m_need && m_pred));
      chk("branch_addr", branch_addr_out, m_addr);
      chk("predict_fail", 32'(predict_fail_out), 32'(m_fail));
      chk("fail_addr", fail_addr_out, m_faddr);
      chk("bq_full", 32'(bq_full_out), 32'(mq.size() == DEPTH));
      chk("stat_resolved", stat_resolved_out, res_m);
      chk("stat_mispredict", stat_mispredict_out, mis_m);

      if (m_hit) begin
        m_j = mq[0].idx;
        if (m_act) begin
          if (pht_m[m_j] < CTR_TOP) pht_m[m_j]++;
        end else begin
          if (pht_m[m_j] > 0) pht_m[m_j]--;
        end
        arch_m = ((arch_m << 1) | int'(m_act)) & HMASK;
        res_m++;
        if (m_fail) begin
          mis_m++;
          mq.delete();
          spec_m = arch_m;
        end else begin
          void'(mq.pop_front());
        end
      end
      if (rdy_in && flush_in) begin
        mq.delete();
        spec_m = arch_m;
      end
      if (m_need) begin
        m_e.pc   = pc_in;
        m_e.fail = m_pred ? m_ts : m_tt;
        m_e.pred = m_pred;
        m_e.idx  = m_idx;
        mq.push_back(m_e);
        spec_m = ((spec_m << 1) | int'(m_pred)) & HMASK;
      end
    end
  end

  task automatic drive(input bit br, input logic [31:0] pc, input logic [31:0] imm, input bit len,
                       input bit cdb, input logic [31:0] ca, input bit cv, input bit fl,
                       input bit rdy);
    @(posedge clk_in);
    #1;
    branch_in      = br;
    pc_in          = pc;
    imm_in         = imm;
    inst_length_in = len;
    foq_full_in    = 1'b0;
    cdb_active_in  = cdb;
    cdb_addr_in    = ca;
    cdb_val_in     = ($urandom() & 32'hFFFF_FFFE) | 32'(cv);
    flush_in       = fl;
    rdy_in         = rdy;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rand_cycle();
    @(posedge clk_in);
    #1;
    rdy_in         = ($urandom_range(0, 9) != 0);
    foq_full_in    = ($urandom_range(0, 9) == 0);
    branch_in      = $urandom_range(0, 1) == 1;
    pc_in          = ($urandom_range(0, 49) == 0) ? 32'h0 : 32'h100 + 32'($urandom_range(0, 40)) * 32'd2;
    imm_in         = $urandom();
    inst_length_in = $urandom_range(0, 1) == 1;
    flush_in       = ($urandom_range(0, 49) == 0);
    cdb_active_in  = $urandom_range(0, 1) == 1;
    if (mq.size() > 0 && $urandom_range(0, 9) < 7) cdb_addr_in = mq[0].pc;
    else cdb_addr_in = 32'h100 + 32'($urandom_range(0, 40)) * 32'd2;
    cdb_val_in     = $urandom();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_need_branch"}, 32'(need_branch_out), 32'h0);
    chk({tag, "_branch_addr"}, branch_addr_out, 32'h0);
    chk({tag, "_predict_fail"}, 32'(predict_fail_out), 32'h0);
    chk({tag, "_fail_addr"}, fail_addr_out, 32'h0);
    chk({tag, "_bq_full"}, 32'(bq_full_out), 32'h0);
    chk({tag, "_stat_resolved"}, stat_resolved_out, 32'h0);
    chk({tag, "_stat_mispredict"}, stat_mispredict_out, 32'h0);
  endtask

  bit hp;

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; branch_in = 1'b1; pc_in = 32'h100; imm_in = 32'h20;
    inst_length_in = 1'b1; foq_full_in = 1'b0; cdb_active_in = 1'b0; cdb_addr_in = 32'h0;
    cdb_val_in = 32'h0; flush_in = 1'b0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(posedge clk_in);
    #1;
    branch_in = 1'b0;
    rst_in = 1'b1;
    chk_en = 1'b1;

    // First prediction at 0x100 is weakly not-taken, resolved taken -> mispredict.
    drive(1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("first_need_branch", 32'(need_branch_out), 32'h0);
    chk("first_branch_addr", branch_addr_out, 32'h104);
    drive(1'b0, 32'h100, 32'h20, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
    chk("first_predict_fail", 32'(predict_fail_out), 32'h1);
    chk("first_fail_addr", fail_addr_out, 32'h120);
    idle();
    chk("first_stat_resolved", stat_resolved_out, 32'd1);
    chk("first_stat_mispredict", stat_mispredict_out, 32'd1);

    // Repeated taken outcomes saturate history at all-ones; round 10 predicts taken.
    for (int r = 2; r <= 10; r++) begin
      drive(1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      if (r == 10) begin
        chk("trained_need_branch", 32'(need_branch_out), 32'h1);
        chk("trained_branch_addr", branch_addr_out, 32'h120);
      end
      drive(1'b0, 32'h100, 32'h20, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
    end

    // Fill the queue, then a 9th branch must be refused even alongside a pop.
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 32'h200 + 32'(i) * 32'd4, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h300, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("full_bq_full", 32'(bq_full_out), 32'h1);
    chk("full_need_branch", 32'(need_branch_out), 32'h0);
    chk("full_branch_addr", branch_addr_out, 32'h0);
    hp = mq[0].pred;
    drive(1'b1, 32'h300, 32'h40, 1'b1, 1'b1, 32'h200, hp, 1'b0, 1'b1);
    chk("full_pop_predict_fail", 32'(predict_fail_out), 32'h0);
    chk("full_pop_need_branch", 32'(need_branch_out), 32'h0);
    idle();
    chk("after_pop_bq_full", 32'(bq_full_out), 32'h0);

    drive(1'b1, 32'h300, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("flush_need_branch", 32'(need_branch_out), 32'h0);
    idle();

    // Out-of-order broadcast is ignored; in-order one pops.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'h200 + 32'(i) * 32'd4, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h204, $urandom_range(0, 1) == 1, 1'b0, 1'b1);
    chk("ooo_predict_fail", 32'(predict_fail_out), 32'h0);
    idle();
    hp = mq[0].pred;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200, hp, 1'b0, 1'b1);
    chk("inorder_predict_fail", 32'(predict_fail_out), 32'h0);
    idle();
    chk("inorder_stat_resolved", stat_resolved_out, 32'd12);
    chk("inorder_stat_mispredict", stat_mispredict_out, 32'd7);

    // Mispredict on the head while a new branch is offered.
    hp = mq[0].pred;
    drive(1'b1, 32'h400, 32'h10, 1'b0, 1'b1, 32'h204, !hp, 1'b0, 1'b1);
    chk("mis_predict_fail", 32'(predict_fail_out), 32'h1);
    chk("mis_need_branch", 32'(need_branch_out), 32'h0);
    idle();
    chk("mis_bq_full", 32'(bq_full_out), 32'h0);

    // rdy low freezes everything.
    drive(1'b1, 32'h500, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h504, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h508, 32'h10, 1'b1, 1'b1, 32'h500, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 1'b0);
      chk("frozen_need_branch", 32'(need_branch_out), 32'h0);
      chk("frozen_predict_fail", 32'(predict_fail_out), 32'h0);
    end
    idle();
    chk("frozen_stat_resolved", stat_resolved_out, 32'd13);
    chk("frozen_stat_mispredict", stat_mispredict_out, 32'd8);

    for (int i = 0; i < 4000; i++) rand_cycle();

    // Asynchronous reset in the middle of a cycle with a branch still offered.
    @(posedge clk_in);
    #1;
    branch_in = 1'b1; pc_in = 32'h600; rdy_in = 1'b1; foq_full_in = 1'b0; flush_in = 1'b0;
    #2;
    chk_en = 1'b0;
    rst_in = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 500; i++) rand_cycle();

    @(posedge clk_in);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
